// File: rtl/ctrl_sequencer.sv
// Step sequencer and instruction register for the multicycle RISC controller.
// Build option: SEQ_ILLEGAL_TRAP_EN makes undefined opcodes trap into HALT instead of acting as NOPs.
//
// state | meaning
// RUN   | stepping through the current instruction
// HALT  | stopped after HLT (or a trapped opcode); waiting for Resume
module ctrl_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic [15:0]         InsWord,
    input  logic                Resume,
    output logic [2:0]          Cnt,
    output logic [4:0]          InsM,
    output logic [1:0]          InsL,
    output logic [2:0]          InsCond,
    output logic                IR_Load,
    output logic                Buff_PC,
    output logic                Halted,
    output logic                Illegal,
    output logic [RETIRE_W-1:0] RetireCnt
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t                state, state_next;
    logic [2:0]            cnt, cnt_next;
    logic [15:0]           ir;
    logic [RETIRE_W-1:0]   retire;
    logic                  retire_inc;
    logic                  illegal_next;
    logic [2:0]            last_step;
    logic                  is_hlt;
    logic                  is_undef;
    logic                  trap_hit;
    logic                  unused_ir_bits;

    assign InsM           = ir[15:11];
    assign InsCond        = ir[10:8];
    assign InsL           = ir[1:0];
    assign unused_ir_bits = ^ir[7:2];

    // Last step of each instruction class; 0 means "never ends on its own".
    always_comb begin
        last_step = 3'd0;
        is_hlt    = 1'b0;
        is_undef  = 1'b0;
        case (ir[15:11])
            5'b00000, 5'b00001, 5'b00010, 5'b00101,
            5'b00111, 5'b01000, 5'b01011,
            5'b10001, 5'b10010:                 last_step = 3'd3;
            5'b00011:                           last_step = 3'd4;
            5'b00100: if (ir[1:0] == 2'b00)     last_step = 3'd4;
                      else                      is_undef  = 1'b1;
            5'b00110: if (ir[1:0] == 2'b00 || ir[1:0] == 2'b01)
                                                last_step = 3'd3;
                      else                      is_undef  = 1'b1;
            5'b11000, 5'b11001, 5'b10000, 5'b10011:
                                                last_step = 3'd2;
            5'b11100: if (ir[1:0] == 2'b00)     last_step = 3'd2;
                      else if (ir[1:0] == 2'b01) is_hlt   = 1'b1;
                      else                      is_undef  = 1'b1;
            default:                            is_undef  = 1'b1;
        endcase
`ifndef SEQ_ILLEGAL_TRAP_EN
        if (is_undef)
            last_step = 3'd2;
`endif
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    assign trap_hit = (state == RUN) && (cnt == 3'd2) && (is_hlt || is_undef);
`else
    assign trap_hit = (state == RUN) && (cnt == 3'd2) && is_hlt;
`endif

    // Buff_PC depends only on registered state so InsWord never reaches it.
    assign Buff_PC = (state == RUN) && (cnt != 3'd0) && (cnt == last_step);
    assign IR_Load = (state == RUN) && (cnt == 3'd0);

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        illegal_next = 1'b0;
        retire_inc   = 1'b0;
        case (state)
            RUN: begin
                if (cnt >= 3'd5 || Buff_PC) begin
                    cnt_next   = 3'd0;
                    retire_inc = Buff_PC;
                end else if (trap_hit) begin
                    state_next   = HALT;
                    illegal_next = is_undef;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            HALT: begin
                if (Resume) begin
                    state_next = RUN;
                    cnt_next   = 3'd0;
                    retire_inc = 1'b1;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state  <= RUN;
            cnt    <= 3'd0;
            ir     <= 16'h0000;
            retire <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (IR_Load)
                ir <= InsWord;
            if (retire_inc)
                retire <= retire + RETIRE_W'(1);
        end
    end

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (Rst)
            illegal_q <= 1'b0;
        else
            illegal_q <= illegal_next;
    end
    assign Illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_next;
    assign Illegal        = 1'b0;
`endif

    assign Cnt       = cnt;
    assign Halted    = (state == HALT);
    assign RetireCnt = retire;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: instruction timing, HLT/resume, reset, undefined opcode, retire wrap.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        Rst;
    logic [15:0] InsWord;
    logic        Resume;
    logic [2:0]  Cnt, Cnt4;
    logic [4:0]  InsM, InsM4;
    logic [1:0]  InsL, InsL4;
    logic [2:0]  InsCond, InsCond4;
    logic        IR_Load, IR_Load4, Buff_PC, Buff_PC4, Halted, Halted4, Illegal, Illegal4;
    logic [15:0] RetireCnt;
    logic [3:0]  RetireCnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.RETIRE_W(16)) dut (
        .clk(clk), .Rst(Rst), .InsWord(InsWord), .Resume(Resume),
        .Cnt(Cnt), .InsM(InsM), .InsL(InsL), .InsCond(InsCond),
        .IR_Load(IR_Load), .Buff_PC(Buff_PC), .Halted(Halted),
        .Illegal(Illegal), .RetireCnt(RetireCnt)
    );

    ctrl_sequencer #(.RETIRE_W(4)) dut4 (
        .clk(clk), .Rst(Rst), .InsWord(InsWord), .Resume(Resume),
        .Cnt(Cnt4), .InsM(InsM4), .InsL(InsL4), .InsCond(InsCond4),
        .IR_Load(IR_Load4), .Buff_PC(Buff_PC4), .Halted(Halted4),
        .Illegal(Illegal4), .RetireCnt(RetireCnt4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst     = 1'b1;
        InsWord = 16'h0001;
        Resume  = 1'b0;
        step();
        step();
        chk("rst_cnt", 32'(Cnt), 0);
        chk("rst_insm", 32'(InsM), 0);
        chk("rst_insl", 32'(InsL), 0);
        chk("rst_halted", 32'(Halted), 0);
        chk("rst_illegal", 32'(Illegal), 0);
        chk("rst_retire", 32'(RetireCnt), 0);

        // ADD
        Rst = 1'b0;
        chk("add_c0_load", 32'(IR_Load), 1);
        chk("add_c0_buff", 32'(Buff_PC), 0);
        step();
        chk("add_c1_cnt", 32'(Cnt), 1);
        chk("add_c1_insl", 32'(InsL), 1);
        chk("add_c1_load", 32'(IR_Load), 0);
        chk("add_c1_buff", 32'(Buff_PC), 0);
        InsWord = 16'h2000;
        step();
        chk("add_c2_cnt", 32'(Cnt), 2);
        chk("add_c2_buff", 32'(Buff_PC), 0);
        step();
        chk("add_c3_cnt", 32'(Cnt), 3);
        chk("add_c3_buff", 32'(Buff_PC), 1);
        step();
        chk("add_end_cnt", 32'(Cnt), 0);
        chk("add_end_buff", 32'(Buff_PC), 0);
        chk("add_retire", 32'(RetireCnt), 1);

        // LDRrr then BNE
        step();
        chk("ldr_insm", 32'(InsM), 5'b00100);
        InsWord = 16'hC000;
        step();
        step();
        chk("ldr_c3_buff", 32'(Buff_PC), 0);
        step();
        chk("ldr_c4_cnt", 32'(Cnt), 4);
        chk("ldr_c4_buff", 32'(Buff_PC), 1);
        step();
        chk("ldr_end_cnt", 32'(Cnt), 0);
        chk("ldr_retire", 32'(RetireCnt), 2);
        step();
        chk("bne_insm", 32'(InsM), 5'b11000);
        chk("bne_cond", 32'(InsCond), 0);
        chk("bne_c1_buff", 32'(Buff_PC), 0);
        InsWord = 16'hE001;
        step();
        chk("bne_c2_buff", 32'(Buff_PC), 1);
        step();
        chk("bne_end_cnt", 32'(Cnt), 0);
        chk("bne_retire", 32'(RetireCnt), 3);

        // HLT
        step();
        InsWord = 16'h2000;
        step();
        chk("hlt_c2_buff", 32'(Buff_PC), 0);
        step();
        chk("hlt_halted", 32'(Halted), 1);
        chk("hlt_cnt", 32'(Cnt), 2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hlt_hold_cnt", 32'(Cnt), 2);
            chk("hlt_hold_buff", 32'(Buff_PC), 0);
        end
        chk("hlt_hold_retire", 32'(RetireCnt), 3);
        chk("hlt_hold_halted", 32'(Halted), 1);
        Resume = 1'b1;
        step();
        Resume = 1'b0;
        chk("resume_cnt", 32'(Cnt), 0);
        chk("resume_halted", 32'(Halted), 0);
        chk("resume_retire", 32'(RetireCnt), 4);

        // Reset in the middle of a load
        step();
        Resume = 1'b1;
        step();
        chk("run_resume_ignored", 32'(Cnt), 2);
        Resume = 1'b0;
        step();
        chk("ldr2_c3", 32'(Cnt), 3);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("midrst_cnt", 32'(Cnt), 0);
        chk("midrst_insm", 32'(InsM), 0);
        chk("midrst_retire", 32'(RetireCnt), 0);

        // Undefined opcode
        InsWord = 16'h7800;
        step();
        chk("undef_insm", 32'(InsM), 5'b01111);
        InsWord = 16'h0001;
        step();
`ifdef SEQ_ILLEGAL_TRAP_EN
        chk("undef_c2_buff", 32'(Buff_PC), 0);
        step();
        chk("undef_illegal", 32'(Illegal), 1);
        chk("undef_halted", 32'(Halted), 1);
        step();
        chk("undef_illegal_off", 32'(Illegal), 0);
        Resume = 1'b1;
        step();
        Resume = 1'b0;
        chk("undef_resume_cnt", 32'(Cnt), 0);
        chk("undef_retire", 32'(RetireCnt), 1);
`else
        chk("undef_c2_buff", 32'(Buff_PC), 1);
        chk("undef_c2_illegal", 32'(Illegal), 0);
        step();
        chk("undef_end_cnt", 32'(Cnt), 0);
        chk("undef_illegal", 32'(Illegal), 0);
        chk("undef_retire", 32'(RetireCnt), 1);
`endif

        // 16 ADDs on the 4-bit retire counter
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("wrap_rst", 32'(RetireCnt4), 0);
        for (int i = 0; i < 15; i++)
            repeat (4) step();
        chk("wrap_15", 32'(RetireCnt4), 15);
        repeat (4) step();
        chk("wrap_0", 32'(RetireCnt4), 0);
        chk("wrap_wide", 32'(RetireCnt), 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
